// File: rtl/s_pipe_fork_manager_if.sv
// Bundles the fork handshake, branch resolution and per-pipe status signals
// of s_pipe_fork_manager. The master drives requests, the slave is the manager.
interface s_pipe_fork_manager_if #(
  parameter int PIPE_CNT = 4,
  parameter int ADDR_W   = 32
);
  localparam int ID_W = $clog2(PIPE_CNT);

  logic                       en;
  logic                       fork_valid;
  logic                       fork_ready;
  logic [ID_W-1:0]            fork_src;
  logic [ADDR_W-1:0]          fork_pc;
  logic [ID_W-1:0]            fork_child;
  logic                       res_valid;
  logic                       res_forked;
  logic [ID_W-1:0]            res_child;
  logic                       res_child_ok;
  logic                       res_mispred;
  logic [ADDR_W-1:0]          res_targ_pc;
  logic [ID_W-1:0]            head_id;
  logic [PIPE_CNT-1:0]        pipe_en;
  logic [PIPE_CNT-1:0]        pipe_flush;
  logic [PIPE_CNT-1:0]        redir_valid;
  logic [PIPE_CNT*ADDR_W-1:0] redir_pc;

  modport master (
    output en, fork_valid, fork_src, fork_pc,
           res_valid, res_forked, res_child, res_child_ok, res_mispred, res_targ_pc,
    input  fork_ready, fork_child, head_id, pipe_en, pipe_flush, redir_valid, redir_pc
  );

  modport slave (
    input  en, fork_valid, fork_src, fork_pc,
           res_valid, res_forked, res_child, res_child_ok, res_mispred, res_targ_pc,
    output fork_ready, fork_child, head_id, pipe_en, pipe_flush, redir_valid, redir_pc
  );
endinterface

// File: rtl/s_pipe_fork_manager.sv
// Speculative pipe manager: lineage masks, fork grant, promote/kill on resolution.
// Optional SPEC_PERF_CNT_EN adds saturating fork/promote/kill counters.
//
// state    | meaning
// S_IDLE   | pipe free, allocatable by a fork
// S_ACTIVE | pipe fetching/executing, mask valid
// S_FLUSH  | pipe killed, counting down before returning to S_IDLE
module s_pipe_fork_manager #(
  parameter int                PIPE_CNT  = 4,
  parameter int                ADDR_W    = 32,
  parameter int                FLUSH_CYC = 2,
  parameter logic [ADDR_W-1:0] START_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  s_pipe_fork_manager_if.slave bus,
  output logic [31:0]          perf_fork,
  output logic [31:0]          perf_promote,
  output logic [31:0]          perf_kill
);
  localparam int ID_W = $clog2(PIPE_CNT);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

  state_t              st_q       [PIPE_CNT];
  state_t              st_d       [PIPE_CNT];
  logic [3:0]          cnt_q      [PIPE_CNT];
  logic [3:0]          cnt_d      [PIPE_CNT];
  logic [PIPE_CNT-1:0] mask_q     [PIPE_CNT];
  logic [PIPE_CNT-1:0] mask_d     [PIPE_CNT];
  logic [ADDR_W-1:0]   redir_pc_q [PIPE_CNT];
  logic [ADDR_W-1:0]   redir_pc_d [PIPE_CNT];
  logic [ID_W-1:0]     head_q, head_d;
  logic [PIPE_CNT-1:0] redir_v_q, redir_v_d;

  logic [PIPE_CNT-1:0] kill;
  logic [ID_W-1:0]     alloc;
  logic                idle_any, res_act, child_legal;
  logic                do_promote, do_prune, do_mispred, bad_res;
  logic                fork_ready, fork_fire;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    redir_pc_d = redir_pc_q;
    head_d     = head_q;
    redir_v_d  = '0;
    kill       = '0;
    idle_any   = 1'b0;
    alloc      = '0;

    res_act     = bus.res_valid & bus.en;
    child_legal = (st_q[bus.res_child] == S_ACTIVE) && (bus.res_child != head_q);
    do_promote  = res_act & bus.res_forked & child_legal & bus.res_child_ok;
    do_prune    = res_act & bus.res_forked & child_legal & ~bus.res_child_ok;
    do_mispred  = res_act & ~bus.res_forked & bus.res_mispred;
    bad_res     = res_act & bus.res_forked & ~child_legal;

    for (int i = 0; i < PIPE_CNT; i++) begin
      if (st_q[i] == S_ACTIVE) begin
        if (do_promote && ((ID_W'(i) == head_q) || !mask_q[i][bus.res_child])) kill[i] = 1'b1;
        if (do_prune && mask_q[i][bus.res_child]) kill[i] = 1'b1;
        if (do_mispred && (ID_W'(i) != head_q)) kill[i] = 1'b1;
      end
    end

    // Scan high-to-low so the lowest-index idle pipe wins
    for (int i = PIPE_CNT - 1; i >= 0; i--) begin
      if (st_q[i] == S_IDLE) begin
        idle_any = 1'b1;
        alloc    = ID_W'(i);
      end
    end

    fork_ready = rst & bus.en & (st_q[bus.fork_src] == S_ACTIVE) & ~kill[bus.fork_src] & idle_any;
    fork_fire  = bus.fork_valid & fork_ready;

    if (bus.en) begin
      for (int i = 0; i < PIPE_CNT; i++) begin
        case (st_q[i])
          S_ACTIVE: begin
            if (kill[i]) begin
              st_d[i]   = S_FLUSH;
              cnt_d[i]  = 4'(FLUSH_CYC);
              mask_d[i] = '0;
            end else if (do_promote) begin
              mask_d[i] = mask_q[i] & ~(PIPE_CNT'(1) << head_q);
            end else if (do_mispred && (ID_W'(i) == head_q)) begin
              mask_d[i] = PIPE_CNT'(1) << head_q;
            end
          end
          S_FLUSH: begin
            if (cnt_q[i] == 4'd1) st_d[i] = S_IDLE;
            else                  cnt_d[i] = cnt_q[i] - 4'd1;
          end
          default: ;
        endcase
      end
      if (do_promote) head_d = bus.res_child;
      if (do_mispred) begin
        redir_v_d[head_q]  = 1'b1;
        redir_pc_d[head_q] = bus.res_targ_pc;
      end
      // Child inherits the parent's post-resolution lineage
      if (fork_fire) begin
        st_d[alloc]       = S_ACTIVE;
        mask_d[alloc]     = mask_d[bus.fork_src] | (PIPE_CNT'(1) << alloc);
        redir_v_d[alloc]  = 1'b1;
        redir_pc_d[alloc] = bus.fork_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_CNT; i++) begin
        st_q[i]       <= (i == 0) ? S_ACTIVE : S_IDLE;
        cnt_q[i]      <= '0;
        mask_q[i]     <= (i == 0) ? PIPE_CNT'(1) : '0;
        redir_pc_q[i] <= (i == 0) ? START_PC : '0;
      end
      head_q    <= '0;
      redir_v_q <= PIPE_CNT'(1);
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      redir_pc_q <= redir_pc_d;
      head_q     <= head_d;
      redir_v_q  <= redir_v_d;
    end
  end

  assign bus.fork_ready  = fork_ready;
  assign bus.fork_child  = alloc;
  assign bus.head_id     = head_q;
  // The boot redirect is held in redir_v_q during reset but only shown after release
  assign bus.redir_valid = rst ? redir_v_q : '0;

  always_comb begin
    bus.pipe_en    = '0;
    bus.pipe_flush = '0;
    bus.redir_pc   = '0;
    for (int i = 0; i < PIPE_CNT; i++) begin
      bus.pipe_en[i]                  = (st_q[i] == S_ACTIVE);
      bus.pipe_flush[i]               = rst & (st_q[i] == S_FLUSH);
      bus.redir_pc[i*ADDR_W +: ADDR_W] = redir_pc_q[i];
    end
  end

  a_res_child_legal: assert property (@(posedge clk) disable iff (!rst) !bad_res)
    else $error("res_child %0d not a live non-head pipe", bus.res_child);

`ifdef SPEC_PERF_CNT_EN
  logic [31:0] perf_fork_q, perf_fork_d, perf_promote_q, perf_promote_d, perf_kill_q, perf_kill_d;
  logic [32:0] kill_sum;

  always_comb begin
    kill_sum = {1'b0, perf_kill_q};
    for (int i = 0; i < PIPE_CNT; i++) kill_sum = kill_sum + {32'd0, (kill[i] & bus.en)};
    perf_kill_d    = kill_sum[32] ? '1 : kill_sum[31:0];
    perf_fork_d    = (fork_fire && perf_fork_q != '1) ? perf_fork_q + 32'd1 : perf_fork_q;
    perf_promote_d = (do_promote && perf_promote_q != '1) ? perf_promote_q + 32'd1 : perf_promote_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fork_q    <= '0;
      perf_promote_q <= '0;
      perf_kill_q    <= '0;
    end else begin
      perf_fork_q    <= perf_fork_d;
      perf_promote_q <= perf_promote_d;
      perf_kill_q    <= perf_kill_d;
    end
  end

  assign perf_fork    = perf_fork_q;
  assign perf_promote = perf_promote_q;
  assign perf_kill    = perf_kill_q;
`else
  assign perf_fork    = '0;
  assign perf_promote = '0;
  assign perf_kill    = '0;
`endif
endmodule

// File: tb/tb_s_pipe_fork_manager.sv
// Directed bench for s_pipe_fork_manager: reset, forks, promote, prune, mispredict, freeze.
module tb_s_pipe_fork_manager;
  localparam int PIPE_CNT = 4;
  localparam int ADDR_W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] perf_fork, perf_promote, perf_kill;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  s_pipe_fork_manager_if #(.PIPE_CNT(PIPE_CNT), .ADDR_W(ADDR_W)) bus ();

  s_pipe_fork_manager #(
    .PIPE_CNT(PIPE_CNT), .ADDR_W(ADDR_W), .FLUSH_CYC(2), .START_PC(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_fork(perf_fork), .perf_promote(perf_promote), .perf_kill(perf_kill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rpc(input int i);
    return bus.redir_pc[i*ADDR_W +: ADDR_W];
  endfunction

  task automatic quiet();
    bus.fork_valid = 1'b0; bus.res_valid = 1'b0; bus.res_forked = 1'b0;
    bus.res_child_ok = 1'b0; bus.res_mispred = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("boot_redir_v", 32'(bus.redir_valid), 32'h1);
    chk("boot_redir_pc", rpc(0), 32'h100);
    tick();
  endtask

  task automatic do_fork(input int src, input logic [31:0] pc, input int child);
    bus.fork_valid = 1'b1; bus.fork_src = 2'(src); bus.fork_pc = pc;
    #1;
    chk("fork_ready", 32'(bus.fork_ready), 32'h1);
    chk("fork_child", 32'(bus.fork_child), 32'(child));
    tick();
    bus.fork_valid = 1'b0;
    chk("fork_redir_v", 32'(bus.redir_valid), 32'h1 << child);
    chk("fork_redir_pc", rpc(child), pc);
  endtask

  initial begin
    bus.en = 1'b1; bus.fork_src = '0; bus.fork_pc = '0; bus.res_child = '0;
    bus.res_targ_pc = '0;
    quiet();

    // During reset: nothing offered, nothing flushing, boot redirect masked
    tick();
    tick();
    bus.fork_valid = 1'b1;
    #1;
    chk("rst_fork_ready", 32'(bus.fork_ready), 32'h0);
    chk("rst_redir_v", 32'(bus.redir_valid), 32'h0);
    chk("rst_flush", 32'(bus.pipe_flush), 32'h0);
    bus.fork_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rel_head", 32'(bus.head_id), 32'h0);
    chk("rel_pipe_en", 32'(bus.pipe_en), 32'h1);
    chk("rel_redir_v", 32'(bus.redir_valid), 32'h1);
    chk("rel_redir_pc", rpc(0), 32'h100);
    tick();
    chk("rel_redir_drop", 32'(bus.redir_valid), 32'h0);

    // Two forks build lineage 0 -> 1 -> 2
    do_fork(0, 32'h200, 1);
    chk("f1_pipe_en", 32'(bus.pipe_en), 32'h3);
    do_fork(1, 32'h300, 2);
    chk("f2_pipe_en", 32'(bus.pipe_en), 32'h7);
    chk("f2_mask1", 32'(dut.mask_q[1]), 32'h3);
    chk("f2_mask2", 32'(dut.mask_q[2]), 32'h7);

    // Promote child 1; a same-cycle fork from the dying head is refused
    bus.res_valid = 1'b1; bus.res_forked = 1'b1; bus.res_child = 2'd1; bus.res_child_ok = 1'b1;
    bus.fork_valid = 1'b1; bus.fork_src = 2'd0;
    #1;
    chk("pr_fork_refused", 32'(bus.fork_ready), 32'h0);
    tick();
    quiet();
    chk("pr_head", 32'(bus.head_id), 32'h1);
    chk("pr_flush", 32'(bus.pipe_flush), 32'h1);
    chk("pr_pipe_en", 32'(bus.pipe_en), 32'h6);
    chk("pr_mask2", 32'(dut.mask_q[2]), 32'h6);
    chk("pr_mask1", 32'(dut.mask_q[1]), 32'h2);
    bus.fork_src = 2'd1;
    #1;
    chk("pr_fork_ready", 32'(bus.fork_ready), 32'h1);
    chk("pr_child3", 32'(bus.fork_child), 32'h3);
    tick();
    chk("pr_flush_c2", 32'(bus.pipe_flush), 32'h1);
    tick();
    chk("pr_flush_done", 32'(bus.pipe_flush), 32'h0);
    chk("pr_child0", 32'(bus.fork_child), 32'h0);
`ifdef SPEC_PERF_CNT_EN
    chk("pr_perf_promote", perf_promote, 32'h1);
    chk("pr_perf_fork", perf_fork, 32'h2);
`else
    chk("pr_perf_promote", perf_promote, 32'h0);
`endif

    // Rebuild the same state, then prune child 1 (kills 1 and 2)
    do_reset();
    do_fork(0, 32'h200, 1);
    do_fork(1, 32'h300, 2);
    bus.res_valid = 1'b1; bus.res_forked = 1'b1; bus.res_child = 2'd1; bus.res_child_ok = 1'b0;
    tick();
    quiet();
    chk("pn_flush", 32'(bus.pipe_flush), 32'h6);
    chk("pn_pipe_en", 32'(bus.pipe_en), 32'h1);
    chk("pn_head", 32'(bus.head_id), 32'h0);

    // Reset in the middle of the flush restarts cleanly
    rst = 1'b0;
    tick();
    chk("mr_flush", 32'(bus.pipe_flush), 32'h0);
    chk("mr_pipe_en", 32'(bus.pipe_en), 32'h1);
    chk("mr_redir_v", 32'(bus.redir_valid), 32'h0);
    rst = 1'b1;
    #1;
    chk("mr_boot_v", 32'(bus.redir_valid), 32'h1);
    chk("mr_boot_pc", rpc(0), 32'h100);
    tick();

    // Fill all four pipes
    do_fork(0, 32'h200, 1);
    do_fork(1, 32'h300, 2);
    do_fork(2, 32'h400, 3);
    chk("full_pipe_en", 32'(bus.pipe_en), 32'hF);
    bus.fork_valid = 1'b1; bus.fork_src = 2'd0; bus.fork_pc = 32'h500;
    #1;
    chk("full_ready", 32'(bus.fork_ready), 32'h0);

    // Kill pipe 3 while the fork waits; it only returns after the flush
    bus.res_valid = 1'b1; bus.res_forked = 1'b1; bus.res_child = 2'd3; bus.res_child_ok = 1'b0;
    #1;
    chk("k3_same_cycle", 32'(bus.fork_ready), 32'h0);
    tick();
    bus.res_valid = 1'b0;
    chk("k3_flush", 32'(bus.pipe_flush), 32'h8);
    chk("k3_ready_c1", 32'(bus.fork_ready), 32'h0);
    bus.en = 1'b0;
    #1;
    chk("en0_ready", 32'(bus.fork_ready), 32'h0);
    tick();
    bus.en = 1'b1;
    chk("en0_hold_flush", 32'(bus.pipe_flush), 32'h8);
    tick();
    chk("k3_flush_c2", 32'(bus.pipe_flush), 32'h8);
    chk("k3_ready_c2", 32'(bus.fork_ready), 32'h0);
    tick();
    chk("k3_flush_done", 32'(bus.pipe_flush), 32'h0);
    chk("k3_ready_again", 32'(bus.fork_ready), 32'h1);
    chk("k3_child", 32'(bus.fork_child), 32'h3);
    tick();
    bus.fork_valid = 1'b0;
    chk("k3_regrant_en", 32'(bus.pipe_en), 32'hF);
    chk("k3_regrant_v", 32'(bus.redir_valid), 32'h8);
    chk("k3_regrant_pc", rpc(3), 32'h500);
    chk("k3_mask3", 32'(dut.mask_q[3]), 32'h9);

    // Redirect pulse drops even while frozen
    bus.en = 1'b0;
    tick();
    chk("en0_redir_drop", 32'(bus.redir_valid), 32'h0);
    chk("en0_pipe_en", 32'(bus.pipe_en), 32'hF);
    bus.en = 1'b1;

    // Drop pipe 3 again, leaving three active pipes
    bus.res_valid = 1'b1; bus.res_forked = 1'b1; bus.res_child = 2'd3; bus.res_child_ok = 1'b0;
    tick();
    quiet();
    tick();
    tick();
    chk("pre_mp_pipe_en", 32'(bus.pipe_en), 32'h7);

    // Mispredict on the head: all others flush, head redirected
    bus.res_valid = 1'b1; bus.res_forked = 1'b0; bus.res_mispred = 1'b1; bus.res_targ_pc = 32'h480;
    tick();
    quiet();
    chk("mp_flush", 32'(bus.pipe_flush), 32'h6);
    chk("mp_pipe_en", 32'(bus.pipe_en), 32'h1);
    chk("mp_redir_v", 32'(bus.redir_valid), 32'h1);
    chk("mp_redir_pc", rpc(0), 32'h480);
    chk("mp_mask0", 32'(dut.mask_q[0]), 32'h1);
    chk("mp_head", 32'(bus.head_id), 32'h0);
`ifdef SPEC_PERF_CNT_EN
    chk("mp_perf_kill", perf_kill, 32'h4);
    chk("mp_perf_fork", perf_fork, 32'h4);
    chk("mp_perf_promote", perf_promote, 32'h0);
`else
    chk("mp_perf_kill", perf_kill, 32'h0);
    chk("mp_perf_fork", perf_fork, 32'h0);
`endif
    tick();
    chk("mp_redir_drop", 32'(bus.redir_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
